// File: rtl/slc3_test_top_if.sv
// Button/switch/display bundle for the SLC-3 board test harness.
// master drives the buttons and switches; slave (the harness) drives LEDs and segments.
interface slc3_test_top_if;
  logic       Run;
  logic       Continue;
  logic [9:0] SW;
  logic [9:0] LED;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  modport master (
    output Run, Continue, SW,
    input  LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  Run, Continue, SW,
    output LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/slc3_test_top.sv
// SLC-3 board test harness: built-in IO echo / XOR / multiply programs on buttons and switches.
// Optional macro PROG_DISPLAY_EN shows PROG[7:0] on HEX5..HEX4 (blank otherwise).
module slc3_test_top #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 16
) (
  input logic            Clk,
  slc3_test_top_if.slave bus
);

  localparam logic [9:0] P_ECHO  = 10'h003;
  localparam logic [9:0] P_LOAD  = 10'h006;
  localparam logic [9:0] P_COUNT = 10'h00B;
  localparam logic [9:0] P_XOR   = 10'h014;
  localparam logic [9:0] P_MUL   = 10'h031;

  typedef enum logic [3:0] {
    S_IDLE, S_ECHO, S_LOAD, S_COUNT, S_ACK,
    S_WAIT_A, S_WAIT_B, S_EXEC, S_RESULT, S_ERROR
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_run_sync, r_cont_sync;
  logic                     r_run_last, r_cont_last;
  logic [9:0]               r_prog, r_a, r_b, r_mplier;
  logic [DATA_W-1:0]        r_data, r_mcand, r_acc;
  logic [3:0]               r_cnt;
  logic [9:0]               r_led, w_led;
  logic [6:0]               r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
  logic                     w_rst_n, w_run_ev, w_cont_ev;
  logic [DATA_W-1:0]        w_addend, w_sw_ext;

  // Reset is both buttons held low, sampled raw on the clock edge.
  assign w_rst_n   = bus.Run | bus.Continue;
  assign w_run_ev  = r_run_last  & ~r_run_sync[SYNC_STAGES-1];
  assign w_cont_ev = r_cont_last & ~r_cont_sync[SYNC_STAGES-1];
  assign w_addend  = r_mplier[0] ? r_mcand : {DATA_W{1'b0}};
  assign w_sw_ext  = {{(DATA_W-10){1'b0}}, bus.SW};

  // Button synchronizers and falling-edge history.
  always_ff @(posedge Clk) begin
    if (!w_rst_n) begin
      r_run_sync  <= {SYNC_STAGES{1'b1}};
      r_cont_sync <= {SYNC_STAGES{1'b1}};
      r_run_last  <= 1'b1;
      r_cont_last <= 1'b1;
    end else begin
      r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], bus.Run};
      r_cont_sync <= {r_cont_sync[SYNC_STAGES-2:0], bus.Continue};
      r_run_last  <= r_run_sync[SYNC_STAGES-1];
      r_cont_last <= r_cont_sync[SYNC_STAGES-1];
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and LED status decode; Run always takes priority over Continue.
  always_comb begin
    w_state_nxt = r_state;
    w_led       = 10'h000;
    if (w_run_ev) begin
      case (bus.SW)
        P_ECHO:       w_state_nxt = S_ECHO;
        P_LOAD:       w_state_nxt = S_LOAD;
        P_COUNT:      w_state_nxt = S_COUNT;
        P_XOR, P_MUL: w_state_nxt = S_ACK;
        default:      w_state_nxt = S_ERROR;
      endcase
    end else begin
      case (r_state)
        S_ACK:    if (w_cont_ev) w_state_nxt = S_WAIT_A; else w_state_nxt = S_ACK;
        S_WAIT_A: if (w_cont_ev) w_state_nxt = S_WAIT_B; else w_state_nxt = S_WAIT_A;
        S_WAIT_B: if (w_cont_ev) w_state_nxt = S_EXEC;   else w_state_nxt = S_WAIT_B;
        S_EXEC: begin
          if ((r_prog == P_XOR) || (r_cnt == 4'd9)) w_state_nxt = S_RESULT;
          else w_state_nxt = S_EXEC;
        end
        S_RESULT: if (w_cont_ev) w_state_nxt = S_WAIT_A; else w_state_nxt = S_RESULT;
        default:  w_state_nxt = r_state;
      endcase
    end
    case (r_state)
      S_ECHO, S_LOAD, S_COUNT, S_ACK: w_led = 10'h001;
      S_WAIT_A: w_led = 10'h002;
      S_WAIT_B: w_led = 10'h003;
      S_EXEC:   if (r_prog == P_MUL) w_led = 10'h200; else w_led = 10'h000;
      S_RESULT: w_led = 10'h004;
      S_ERROR:  w_led = 10'h3FF;
      default:  w_led = 10'h000;
    endcase
  end

  // Program datapath: operand capture, echo/count, XOR and 10-step shift-add multiply.
  always_ff @(posedge Clk) begin
    if (!w_rst_n) begin
      r_prog   <= 10'h000;
      r_a      <= 10'h000;
      r_b      <= 10'h000;
      r_data   <= {DATA_W{1'b0}};
      r_mcand  <= {DATA_W{1'b0}};
      r_mplier <= 10'h000;
      r_acc    <= {DATA_W{1'b0}};
      r_cnt    <= 4'd0;
    end else if (w_run_ev) begin
      r_prog <= bus.SW;
      r_data <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_ECHO:   r_data <= w_sw_ext;
        S_LOAD:   if (w_cont_ev) r_data <= w_sw_ext;
        S_COUNT:  if (w_cont_ev) r_data <= r_data + {{(DATA_W-1){1'b0}}, 1'b1};
        S_WAIT_A: if (w_cont_ev) r_a <= bus.SW;
        S_WAIT_B: begin
          if (w_cont_ev) begin
            r_b      <= bus.SW;
            r_mplier <= bus.SW;
            r_mcand  <= {{(DATA_W-10){1'b0}}, r_a};
            r_acc    <= {DATA_W{1'b0}};
            r_cnt    <= 4'd0;
          end
        end
        S_EXEC: begin
          if (r_prog == P_XOR) begin
            r_data <= {{(DATA_W-10){1'b0}}, r_a ^ r_b};
          end else begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= {r_mcand[DATA_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[9:1]};
            r_cnt    <= r_cnt + 4'd1;
            if (r_cnt == 4'd9) r_data <= r_acc + w_addend;
          end
        end
        S_ERROR:  r_data <= {DATA_W{1'b0}};
        default:  r_data <= r_data;
      endcase
    end
  end

  // Registered LED and segment outputs.
  always_ff @(posedge Clk) begin
    if (!w_rst_n) begin
      r_led  <= 10'h000;
      r_hex0 <= 7'h40;
      r_hex1 <= 7'h40;
      r_hex2 <= 7'h40;
      r_hex3 <= 7'h40;
      r_hex4 <= 7'h7F;
      r_hex5 <= 7'h7F;
    end else begin
      r_led  <= w_led;
      r_hex0 <= seg7(r_data[3:0]);
      r_hex1 <= seg7(r_data[7:4]);
      r_hex2 <= seg7(r_data[11:8]);
      r_hex3 <= seg7(r_data[15:12]);
`ifdef PROG_DISPLAY_EN
      r_hex4 <= seg7(r_prog[3:0]);
      r_hex5 <= seg7(r_prog[7:4]);
`else
      r_hex4 <= 7'h7F;
      r_hex5 <= 7'h7F;
`endif
    end
  end

  assign bus.LED  = r_led;
  assign bus.HEX0 = r_hex0;
  assign bus.HEX1 = r_hex1;
  assign bus.HEX2 = r_hex2;
  assign bus.HEX3 = r_hex3;
  assign bus.HEX4 = r_hex4;
  assign bus.HEX5 = r_hex5;

endmodule

// File: tb/tb_slc3_test_top.sv
// Directed scoreboard bench for slc3_test_top (default build: HEX5..HEX4 blank).
module tb_slc3_test_top;

  typedef struct {
    string       tag;
    logic [9:0]  led;
    logic [15:0] data;
  } exp_t;

  logic Clk = 1'b0;
  slc3_test_top_if bus ();
  slc3_test_top #(.SYNC_STAGES(2), .DATA_W(16)) dut (.Clk(Clk), .bus(bus));

  always #5 Clk = ~Clk;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          busy_cnt = 0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [27:0] hex4(input logic [15:0] d);
    return {seg_tab[d[15:12]], seg_tab[d[11:8]], seg_tab[d[7:4]], seg_tab[d[3:0]]};
  endfunction

  task automatic expect_out(input string tag, input logic [9:0] led, input logic [15:0] data);
    exp_t e;
    e.tag = tag; e.led = led; e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [27:0] obs_hex;
    e = sb.pop_front();
    obs_hex = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    vectors++;
    assert (bus.LED === e.led) else begin
      miscompares++;
      $error("FAIL %s.led observed %h expected %h", e.tag, bus.LED, e.led);
    end
    vectors++;
    assert (obs_hex === hex4(e.data)) else begin
      miscompares++;
      $error("FAIL %s.hex observed %h expected %h (data %h)", e.tag, obs_hex, hex4(e.data), e.data);
    end
    vectors++;
    assert ({bus.HEX5, bus.HEX4} === 14'h3FFF) else begin
      miscompares++;
      $error("FAIL %s.blank observed %h expected %h", e.tag, {bus.HEX5, bus.HEX4}, 14'h3FFF);
    end
  endtask

  task automatic check_busy(input string tag, input int exp_cnt);
    vectors++;
    assert (busy_cnt == exp_cnt) else begin
      miscompares++;
      $error("FAIL %s.busy observed %0d expected %0d", tag, busy_cnt, exp_cnt);
    end
  endtask

  // Hold a button low for `hold` cycles, release, settle; counts LED[9] high cycles throughout.
  task automatic press(input bit is_run, input int hold);
    busy_cnt = 0;
    if (is_run) bus.Run = 1'b0; else bus.Continue = 1'b0;
    repeat (hold) begin @(negedge Clk); if (bus.LED[9] === 1'b1) busy_cnt++; end
    bus.Run = 1'b1;
    bus.Continue = 1'b1;
    repeat (30) begin @(negedge Clk); if (bus.LED[9] === 1'b1) busy_cnt++; end
  endtask

  task automatic set_sw(input logic [9:0] v);
    bus.SW = v;
  endtask

  initial begin
    bus.Run = 1'b0;
    bus.Continue = 1'b0;
    bus.SW = 10'h000;
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.Continue = 1'b1;
    expect_out("reset", 10'h000, 16'h0000);
    check_out();
    repeat (3) @(negedge Clk);
    expect_out("idle", 10'h000, 16'h0000);
    check_out();

    // IO echo
    set_sw(10'h003); press(1'b1, 3);
    set_sw(10'h155); repeat (3) @(negedge Clk);
    expect_out("echo155", 10'h001, 16'h0155); check_out();
    set_sw(10'h2A0); repeat (3) @(negedge Clk);
    expect_out("echo2a0", 10'h001, 16'h02A0); check_out();
    press(1'b0, 3);
    expect_out("echo_cont", 10'h001, 16'h02A0); check_out();

    // Load on Continue
    set_sw(10'h006); press(1'b1, 3);
    set_sw(10'h123); repeat (5) @(negedge Clk);
    expect_out("load_hold", 10'h001, 16'h0000); check_out();
    press(1'b0, 3);
    expect_out("load_cont", 10'h001, 16'h0123); check_out();

    // Counter
    set_sw(10'h00B); press(1'b1, 3);
    expect_out("count0", 10'h001, 16'h0000); check_out();
    for (int i = 0; i < 3; i++) press(1'b0, 3);
    expect_out("count3", 10'h001, 16'h0003); check_out();

    // XOR chain
    set_sw(10'h014); press(1'b1, 3);
    expect_out("xor_ack", 10'h001, 16'h0000); check_out();
    press(1'b0, 3);
    expect_out("xor_wa", 10'h002, 16'h0000); check_out();
    set_sw(10'h30F); press(1'b0, 3);
    expect_out("xor_wb", 10'h003, 16'h0000); check_out();
    set_sw(10'h0F0); press(1'b0, 3);
    expect_out("xor_res", 10'h004, 16'h03FF); check_out();
    check_busy("xor", 0);

    // Multiply chain
    set_sw(10'h031); press(1'b1, 3);
    press(1'b0, 3);
    set_sw(10'h002); press(1'b0, 3);
    set_sw(10'h003); press(1'b0, 3);
    expect_out("mul_2x3", 10'h004, 16'h0006); check_out();
    check_busy("mul_2x3", 10);
    press(1'b0, 3);
    expect_out("mul_next", 10'h002, 16'h0006); check_out();
    set_sw(10'h3FF); press(1'b0, 3);
    press(1'b0, 3);
    expect_out("mul_max", 10'h004, 16'hF801); check_out();
    check_busy("mul_max", 10);

    // Restart from WAIT_B, then long hold gives one advance
    set_sw(10'h014); press(1'b1, 3);
    press(1'b0, 3);
    set_sw(10'h005); press(1'b0, 3);
    expect_out("rst_wb", 10'h003, 16'h0000); check_out();
    set_sw(10'h014); press(1'b1, 3);
    expect_out("restart", 10'h001, 16'h0000); check_out();
    press(1'b0, 3);
    expect_out("restart_wa", 10'h002, 16'h0000); check_out();
    press(1'b0, 50);
    expect_out("hold50", 10'h003, 16'h0000); check_out();

    // Unsupported program
    set_sw(10'h2AA); press(1'b1, 3);
    expect_out("error", 10'h3FF, 16'h0000); check_out();
    press(1'b0, 3);
    expect_out("error_cont", 10'h3FF, 16'h0000); check_out();

    // Mid-run reset from a non-idle program
    set_sw(10'h00B); press(1'b1, 3);
    press(1'b0, 3);
    bus.Run = 1'b0;
    bus.Continue = 1'b0;
    @(negedge Clk);
    bus.Run = 1'b1;
    bus.Continue = 1'b1;
    expect_out("reset2", 10'h000, 16'h0000); check_out();
    repeat (5) @(negedge Clk);
    expect_out("reset2_idle", 10'h000, 16'h0000); check_out();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
